// File: rtl/arb_mux.sv
// Arbitrating N:1 mux (directed select or round-robin) feeding a single-entry output register.
// Latency 1 cycle; inputs stall while the held word is not accepted, with no bubble on drain.
module arb_mux #(
    parameter  int WIDTH    = 32,
    parameter  int CHANNELS = 4,
    localparam int SW       = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SW-1:0]             sel,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SW-1:0]             out_chan
);

    logic [WIDTH-1:0] w_ch [CHANNELS];
    logic [SW-1:0]    w_idx;
    logic [SW-1:0]    w_rr_idx;
    logic             w_rr_vld;
    logic             w_dir_vld;
    logic [SW-1:0]    w_gnt;
    logic             w_gnt_vld;
    logic             w_load;

    logic [WIDTH-1:0] r_out_data;
    logic             r_out_vld;
    logic [SW-1:0]    r_out_chan;
    logic [SW-1:0]    r_ptr;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_unpack
        assign w_ch[i] = in_data[i*WIDTH +: WIDTH];
    end

    // Scan from the farthest candidate back to ptr+1 so the nearest valid one wins.
    always_comb begin
        w_rr_vld = 1'b0;
        w_rr_idx = '0;
        w_idx    = '0;
        for (int k = CHANNELS; k >= 1; k--) begin
            w_idx = SW'((int'(r_ptr) + k) % CHANNELS);
            if (in_valid[w_idx]) begin
                w_rr_vld = 1'b1;
                w_rr_idx = w_idx;
            end
        end
    end

    assign w_dir_vld = (int'(sel) < CHANNELS) && in_valid[sel];
    assign w_gnt     = mode ? w_rr_idx : sel;
    assign w_gnt_vld = mode ? w_rr_vld : w_dir_vld;
    assign w_load    = !r_out_vld || out_ready;

    always_comb begin
        in_ready = '0;
        if (rst_n && w_load && w_gnt_vld) begin
            in_ready[w_gnt] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data <= '0;
            r_out_vld  <= 1'b0;
            r_out_chan <= '0;
            r_ptr      <= SW'(CHANNELS - 1);
        end else if (w_load) begin
            r_out_vld <= w_gnt_vld;
            if (w_gnt_vld) begin
                r_out_data <= w_ch[w_gnt];
                r_out_chan <= w_gnt;
                if (mode) begin
                    r_ptr <= w_gnt;
                end
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_vld;
    assign out_chan  = r_out_chan;

endmodule
